fecha_rtc_writer: RTL and testbench
===================================

FECHA_RTC_WRITER -- requirements
Module: fecha_rtc_writer

Interface
REQ-001 Parameter ADDR_DIA, default 8'h24, RTC register address for the day.
REQ-002 Parameter ADDR_MES, default 8'h25, RTC register address for the month.
REQ-003 Parameter ADDR_YEAR, default 8'h26, RTC register address for the year.
REQ-004 Parameter TIMEOUT, default 1000, maximum cycles to wait for bus_ack per write (16-bit counter).
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 diaC  input  8  edited day, binary.
REQ-008 mesC  input  8  edited month, binary.
REQ-009 yearC  input  8  edited year, binary.
REQ-010 commit  input  1  level from the edit controller; its rising edge requests an RTC write.
REQ-011 bus_ack  input  1  RTC bus write-complete acknowledge.
REQ-012 bus_req  output  1  write request to the RTC bus.
REQ-013 bus_addr  output  8  RTC register address.
REQ-014 bus_data  output  8  packed BCD write data (tens in [7:4], units in [3:0]).
REQ-015 busy  output  1  high from snapshot until the sequence ends.
REQ-016 done  output  1  one-cycle pulse on successful completion of all three writes.
REQ-017 err  output  1  one-cycle pulse on abort (timeout or range fault).

Function
REQ-018 States: IDLE, SNAP, CONV, REQ, WAIT_ACK, GAP, FIN; the FSM SHALL use only these states.
REQ-019 The block SHALL detect the commit rising edge with an internal registered copy; a level held high SHALL NOT retrigger.
REQ-020 On an edge seen in IDLE at edge k, the block SHALL snapshot diaC/mesC/yearC at edge k (SNAP), set busy, and ignore later input changes.
REQ-021 CONV SHALL register the BCD of all three snapshots at edge k+1; values above 99 SHALL saturate to 8'h99.
REQ-022 bus_req SHALL first be high after edge k+2, with bus_addr=ADDR_DIA and bus_data=BCD(day).
REQ-023 Write order SHALL be day, month, year.
REQ-024 bus_req, bus_addr and bus_data SHALL stay constant while in WAIT_ACK until bus_ack is sampled high.
REQ-025 On bus_ack sampled high, bus_req SHALL drop the next cycle and stay low for exactly one GAP cycle before the next write.
REQ-026 After the year write is acknowledged, FIN SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-027 If bus_ack is not seen within TIMEOUT cycles of a bus_req assertion, the block SHALL drop bus_req, pulse err, clear busy and return to IDLE, skipping the remaining writes.
REQ-028 commit edges arriving while busy SHALL be discarded, not queued.
REQ-029 bus_ack while bus_req is low SHALL be ignored.
REQ-030 bus_addr and bus_data SHALL read 0 whenever bus_req is low.

Reset
REQ-031 Asserting reset at any time, including mid-write, SHALL force IDLE and drive bus_req, busy, done, err, bus_addr and bus_data to 0 without waiting for a clock edge.
REQ-032 Reset SHALL clear the commit edge register, the snapshots, the BCD registers and the timeout counter to 0.
REQ-033 If commit is high when reset releases, no write SHALL start until commit goes low and then high again.

Configuration
REQ-034 Macro FECHA_RANGE_CHECK_EN: when defined, CONV SHALL check day 1..31, month 1..12 and year 0..99.
REQ-035 With FECHA_RANGE_CHECK_EN defined, any out-of-range value SHALL pulse err, issue no bus_req and return to IDLE.
REQ-036 With FECHA_RANGE_CHECK_EN undefined, no check SHALL be made; writes SHALL proceed with saturated BCD.

Verification
REQ-037 diaC=15, mesC=8, yearC=16, commit edge, bus_ack returned 3 cycles after each req -> writes (24h,15h),(25h,08h),(26h,16h), one GAP cycle between writes, then one done pulse.
REQ-038 Same stimulus with bus_ack never returned and TIMEOUT=20 -> bus_req drops after 20 cycles, err pulses once, and no month or year write is issued.
REQ-039 diaC=0 with FECHA_RANGE_CHECK_EN defined -> err pulses at CONV with no bus_req; with the macro undefined -> write (24h,00h) is issued.
REQ-040 Second commit edge during the month write, plus inputs changed mid-sequence -> exactly three writes, carrying the snapshot values.
REQ-041 Reset asserted in WAIT_ACK of the month write -> bus_req and busy fall immediately (asynchronously); with commit held high, no new write starts after release.
REQ-042 yearC=150, range check undefined -> year write data is 8'h99.

Source files
------------

// File: rtl/fecha_rtc_writer_if.sv
// Purpose : signal bundle between the date edit controller / RTC bus and fecha_rtc_writer.
// Ports   : edit side diaC/mesC/yearC/commit, bus side bus_req/bus_addr/bus_data/bus_ack,
//           status busy/done/err. The slave modport is the writer, the master modport is its environment.
interface fecha_rtc_writer_if;
  logic [7:0] diaC;
  logic [7:0] mesC;
  logic [7:0] yearC;
  logic       commit;
  logic       bus_ack;
  logic       bus_req;
  logic [7:0] bus_addr;
  logic [7:0] bus_data;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  diaC, mesC, yearC, commit, bus_ack,
    output bus_req, bus_addr, bus_data, busy, done, err
  );

  modport master (
    output diaC, mesC, yearC, commit, bus_ack,
    input  bus_req, bus_addr, bus_data, busy, done, err
  );
endinterface

// File: rtl/fecha_rtc_writer.sv
// Purpose : on a commit rising edge, snapshot day/month/year, convert to packed BCD and write
//           them to the RTC as three bus writes (day, month, year), then pulse done or err.
// Latency : snapshot at edge k, BCD at k+1, first bus_req after k+2; one idle GAP cycle between writes.
// Backpressure: each write holds bus_req/addr/data until bus_ack; gives up after TIMEOUT cycles.
// Ports   : clk, reset (async, active high); bus = fecha_rtc_writer_if.slave.
// Options : define FECHA_RANGE_CHECK_EN to reject out-of-range dates (day 1..31, month 1..12,
//           year 0..99) with an err pulse and no bus activity.
module fecha_rtc_writer #(
  parameter logic [7:0]  ADDR_DIA  = 8'h24,
  parameter logic [7:0]  ADDR_MES  = 8'h25,
  parameter logic [7:0]  ADDR_YEAR = 8'h26,
  parameter int unsigned TIMEOUT   = 1000
) (
  input logic               clk,
  input logic               reset,
  fecha_rtc_writer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SNAP, CONV, REQ, WAIT_ACK, GAP, FIN
  } state_t;

  localparam logic [15:0] C_TMO = 16'(TIMEOUT);

  state_t      r_state;
  state_t      w_next;
  logic        r_commit_q;
  logic        r_armed;
  logic [7:0]  r_dia, r_mes, r_year;
  logic [7:0]  r_bcd_dia, r_bcd_mes, r_bcd_year;
  logic [15:0] r_tmo;
  logic [1:0]  r_idx;
  logic        r_err;

  logic        w_commit_rise;
  logic        w_range_ok;
  logic        w_snap;
  logic        w_abort;
  logic        w_ack;
  logic        w_req;
  logic        w_busy;
  logic        w_done;
  logic [7:0]  w_addr;
  logic [7:0]  w_data;

  // Saturating binary-to-packed-BCD for 0..99.
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    logic [7:0] t;
    if (v > 8'd99) return 8'h99;
    t = v / 8'd10;
    return (t << 4) | (v - t * 8'd10);
  endfunction

  // r_armed stays low until commit has been seen low, so a commit held high
  // across reset release is not mistaken for a fresh edge.
  assign w_commit_rise = bus.commit & ~r_commit_q & r_armed;

`ifdef FECHA_RANGE_CHECK_EN
  assign w_range_ok = (r_dia >= 8'd1) && (r_dia <= 8'd31) &&
                      (r_mes >= 8'd1) && (r_mes <= 8'd12) &&
                      (r_year <= 8'd99);
`else
  assign w_range_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_snap  = 1'b0;
    w_abort = 1'b0;
    w_ack   = 1'b0;
    w_req   = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_addr  = 8'h00;
    w_data  = 8'h00;
    case (r_state)
      IDLE: begin
        if (w_commit_rise) begin
          w_snap = 1'b1;
          w_next = SNAP;
        end
      end
      SNAP: begin
        w_busy = 1'b1;
        w_next = CONV;
      end
      CONV: begin
        w_busy = 1'b1;
        if (!w_range_ok) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else begin
          w_next = REQ;
        end
      end
      REQ: begin
        w_busy = 1'b1;
        w_req  = 1'b1;
        // REQ is the first bus_req cycle and already counts toward the timeout.
        if (bus.bus_ack) begin
          w_ack = 1'b1;
        end else if (C_TMO <= 16'd1) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else begin
          w_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        w_busy = 1'b1;
        w_req  = 1'b1;
        // r_tmo counts bus_req cycles already completed for this write.
        if (bus.bus_ack) begin
          w_ack = 1'b1;
        end else if (16'(r_tmo + 16'd1) >= C_TMO) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end
      end
      GAP: begin
        w_busy = 1'b1;
        w_next = REQ;
      end
      FIN: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase

    if (w_ack) w_next = (r_idx == 2'd2) ? FIN : GAP;

    if (w_req) begin
      case (r_idx)
        2'd0:    begin w_addr = ADDR_DIA;  w_data = r_bcd_dia;  end
        2'd1:    begin w_addr = ADDR_MES;  w_data = r_bcd_mes;  end
        default: begin w_addr = ADDR_YEAR; w_data = r_bcd_year; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_commit_q <= 1'b0;
      r_armed    <= 1'b0;
      r_dia      <= 8'h00;
      r_mes      <= 8'h00;
      r_year     <= 8'h00;
      r_bcd_dia  <= 8'h00;
      r_bcd_mes  <= 8'h00;
      r_bcd_year <= 8'h00;
      r_tmo      <= 16'h0000;
      r_idx      <= 2'd0;
      r_err      <= 1'b0;
    end else begin
      r_commit_q <= bus.commit;
      if (!bus.commit) r_armed <= 1'b1;
      r_err <= w_abort;
      if (w_snap) begin
        r_dia  <= bus.diaC;
        r_mes  <= bus.mesC;
        r_year <= bus.yearC;
        r_idx  <= 2'd0;
      end
      if (r_state == SNAP) begin
        r_bcd_dia  <= to_bcd(r_dia);
        r_bcd_mes  <= to_bcd(r_mes);
        r_bcd_year <= to_bcd(r_year);
      end
      if (r_state == REQ)           r_tmo <= 16'd1;
      else if (r_state == WAIT_ACK) r_tmo <= r_tmo + 16'd1;
      if (w_ack && (r_idx != 2'd2)) r_idx <= r_idx + 2'd1;
    end
  end

  assign bus.bus_req  = w_req;
  assign bus.bus_addr = w_addr;
  assign bus.bus_data = w_data;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_fecha_rtc_writer.sv
// Purpose : randomized self-checking bench for fecha_rtc_writer against a date-to-BCD write model.
// Ports   : none; instantiates fecha_rtc_writer_if and the DUT with TIMEOUT=20.
module tb_fecha_rtc_writer;
  localparam int TMO = 20;
`ifdef FECHA_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  fecha_rtc_writer_if bus_if ();

  fecha_rtc_writer #(.TIMEOUT(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal value to packed BCD with saturation at 99.
  function automatic logic [7:0] ref_bcd(input int v);
    if (v > 99) return 8'h99;
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic bit ref_ok(input int d, input int m, input int y);
    return (d >= 1) && (d <= 31) && (m >= 1) && (m <= 12) && (y <= 99);
  endfunction

  task automatic run_txn(input int d, input int m, input int y, input int ack_dly,
                         input bit no_ack, input bit retrig, input bit mid_reset);
    logic [7:0] obs_a[$];
    logic [7:0] obs_d[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_d[$];
    logic [7:0] cur_a, cur_d;
    int  lat = -1, req_len = 0, max_len = 0, gap_len = 0;
    int  done_cnt = 0, err_cnt = 0, tail = 0, n_cmp;
    bit  req_prev = 1'b0, unstable = 1'b0, nz_idle = 1'b0, bad_gap = 1'b0;
    bit  busy1 = 1'b0, rst_hit = 1'b0, seen = 1'b0;

    @(negedge clk);
    bus_if.diaC   = 8'(d);
    bus_if.mesC   = 8'(m);
    bus_if.yearC  = 8'(y);
    bus_if.commit = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (bus_if.bus_req) begin
        if (!req_prev) begin
          cur_a = bus_if.bus_addr;
          cur_d = bus_if.bus_data;
          obs_a.push_back(cur_a);
          obs_d.push_back(cur_d);
          req_len = 0;
          if (lat < 0) lat = cyc;
          if (obs_a.size() > 1 && gap_len != 1) bad_gap = 1'b1;
        end else if (bus_if.bus_addr !== cur_a || bus_if.bus_data !== cur_d) begin
          unstable = 1'b1;
        end
        req_len++;
        if (req_len > max_len) max_len = req_len;
      end else begin
        if (bus_if.bus_addr !== 8'h00 || bus_if.bus_data !== 8'h00) nz_idle = 1'b1;
        if (req_prev) gap_len = 0;
        gap_len++;
      end
      if (cyc == 1) busy1 = bus_if.busy;
      done_cnt += int'(bus_if.done);
      err_cnt  += int'(bus_if.err);
      req_prev = bus_if.bus_req;

      bus_if.bus_ack = 1'b0;
      if (bus_if.bus_req && !no_ack && req_len == ack_dly + 1) bus_if.bus_ack = 1'b1;

      if (retrig && obs_a.size() == 2 && bus_if.bus_req && req_len == 1) begin
        bus_if.commit = 1'b0;
        bus_if.diaC   = 8'($urandom_range(0, 255));
        bus_if.mesC   = 8'($urandom_range(0, 255));
        bus_if.yearC  = 8'($urandom_range(0, 255));
      end
      if (retrig && obs_a.size() == 2 && bus_if.bus_req && req_len == 2) bus_if.commit = 1'b1;

      if (mid_reset && obs_a.size() == 2 && bus_if.bus_req && req_len == 3) begin
        rst_hit = 1'b1;
        break;
      end
      if (done_cnt + err_cnt > 0) tail++;
      if (tail > 5) break;
    end

    if (mid_reset) begin
      check("rst_reached_month_wait", rst_hit, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_async_req", bus_if.bus_req, 0);
      check("rst_async_busy", bus_if.busy, 0);
      check("rst_async_addr", bus_if.bus_addr, 0);
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      reset = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (bus_if.bus_req || bus_if.busy) seen = 1'b1;
      end
      check("rst_commit_high_no_start", seen, 0);
      bus_if.commit = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end

    // Reference outcome for this commit.
    if (RC && !ref_ok(d, m, y)) begin
      n_cmp = 0;
    end else begin
      exp_a = '{8'h24, 8'h25, 8'h26};
      exp_d = '{ref_bcd(d), ref_bcd(m), ref_bcd(y)};
      n_cmp = no_ack ? 1 : 3;
    end
    check("finished", (done_cnt + err_cnt > 0), 1);
    check("busy_after_snap", busy1, 1);
    check("n_writes", obs_a.size(), n_cmp);
    for (int i = 0; i < n_cmp && i < obs_a.size(); i++) begin
      check($sformatf("addr%0d", i), obs_a[i], exp_a[i]);
      check($sformatf("data%0d", i), obs_d[i], exp_d[i]);
    end
    if (n_cmp > 0) check("first_req_latency", lat, 3);
    if (no_ack && n_cmp > 0) check("timeout_req_len", max_len, TMO);
    check("done_pulses", done_cnt, (n_cmp == 3) ? 1 : 0);
    check("err_pulses", err_cnt, (n_cmp == 3) ? 0 : 1);
    check("req_stable", unstable, 0);
    check("idle_bus_zero", nz_idle, 0);
    check("one_gap_cycle", bad_gap, 0);

    bus_if.bus_ack = 1'b0;
    bus_if.commit  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit seen;
    reset          = 1'b1;
    bus_if.diaC    = 8'h00;
    bus_if.mesC    = 8'h00;
    bus_if.yearC   = 8'h00;
    bus_if.commit  = 1'b0;
    bus_if.bus_ack = 1'b0;
    #1;
    check("reset_req", bus_if.bus_req, 0);
    check("reset_busy", bus_if.busy, 0);
    check("reset_done", bus_if.done, 0);
    check("reset_err", bus_if.err, 0);
    check("reset_addr", bus_if.bus_addr, 0);
    check("reset_data", bus_if.bus_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // A stray ack while idle must not start anything.
    seen = 1'b0;
    bus_if.bus_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.bus_req || bus_if.busy || bus_if.done || bus_if.err) seen = 1'b1;
    end
    bus_if.bus_ack = 1'b0;
    check("idle_ack_ignored", seen, 0);

    run_txn(15, 8, 16, 3, 1'b0, 1'b0, 1'b0);   // nominal date
    run_txn(15, 8, 16, 3, 1'b1, 1'b0, 1'b0);   // ack never returned
    run_txn(0, 8, 16, 3, 1'b0, 1'b0, 1'b0);    // day out of range
    run_txn(15, 8, 150, 2, 1'b0, 1'b0, 1'b0);  // saturated year
    run_txn(31, 12, 99, 0, 1'b0, 1'b0, 1'b0);  // ack in first req cycle
    run_txn(int'($urandom_range(1, 31)), int'($urandom_range(1, 12)),
            int'($urandom_range(0, 99)), 4, 1'b0, 1'b1, 1'b0);  // retrigger + input change
    run_txn(10, 3, 20, 10, 1'b0, 1'b0, 1'b1);  // reset mid month write
    for (int t = 0; t < 12; t++) begin
      run_txn(int'($urandom_range(0, 40)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 160)), int'($urandom_range(0, 6)),
              ($urandom_range(0, 7) == 0), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
